speed_display_ctrl: RTL and testbench

Sequencing controller between the speed-measurement core and the two-digit 7-segment decoder. It accepts binary speed samples (km/h) and converts each to two BCD digits with an iterative divide-by-10. It publishes the digits on the decoder's `msg`/`noti` interface and arbitrates between live, peak-hold and timeout-blank display sources. One instance per display board, clocked from the display clock domain.

---
 rtl/disp_pkg.sv | 19 +
 rtl/bin2bcd_seq.sv | 42 ++++
 rtl/speed_display_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_speed_display_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and display codes for the speed display controller.
// Pure declarations; no timing or flow control of its own.
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        NOTIFY = 2'd2
    } ctrl_state_t;

    localparam logic [7:0] BLANK_CODE = 8'hFF;
    localparam logic [7:0] OVF_CODE   = 8'h99;
    localparam logic [7:0] BCD_LIMIT  = 8'd99;

    function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative subtract-10 binary to two-digit BCD converter for values 0-99.
// Latency value/10 + 1 clocks from start to a one-clock done pulse; a new start restarts it.
module bin2bcd_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] value,
    output logic       done,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [6:0] rem;
    logic       active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem    <= '0;
            tens   <= '0;
            active <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem    <= value;
                tens   <= '0;
                active <= 1'b1;
            end else if (active) begin
                if (rem >= 7'd10) begin
                    rem  <= rem - 7'd10;
                    tens <= tens + 4'd1;
                end else begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

    assign ones = rem[3:0];

endmodule

// File: rtl/speed_display_ctrl.sv
// Converts speed samples to BCD and publishes them to the 7-segment decoder with a noti pulse.
// Update latency V/10+2 clocks (1 for saturated/blank); samples arriving while busy park in a one-deep latest-wins slot.
module speed_display_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned NOTI_CYCLES  = 4,
    parameter int unsigned BLANK_CYCLES = 2_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] spd,
    input  logic       spd_vld,
    input  logic       peak_mode,
    output logic [7:0] msg,
    output logic       noti,
    output logic       busy,
    output logic       ovf
);

    localparam int NOTI_W = $clog2(NOTI_CYCLES + 1);
    localparam int IDLE_W = $clog2(BLANK_CYCLES);

    ctrl_state_t state, next_state;

    logic [7:0]        peak;
    logic              peak_mode_q;
    logic              slot_vld;
    logic [7:0]        slot_dat;
    logic [IDLE_W-1:0] idle_cnt;
    logic              armed;
    logic              blank_pend;
    logic [NOTI_W-1:0] noti_cnt;
    logic [7:0]        code_q;
    logic              code_ovf_q;

    logic              conv_done;
    logic [3:0]        conv_tens;
    logic [3:0]        conv_ones;

    logic              timeout_fire;
    logic              take_fresh;
    logic              take_slot;
    logic              take_sample;
    logic              take_blank;
    logic [7:0]        raw;
    logic [7:0]        src;
    logic              peak_grow;
    logic              sample_go;
    logic              sat;
    logic              go_conv;
    logic              go_direct;

    logic              msg_load;
    logic [7:0]        msg_next;
    logic              ovf_next;
    logic              noti_end;

    // Acceptance priority in IDLE: fresh strobe, then parked sample, then blank.
    always_comb begin
        timeout_fire = armed && !spd_vld && (idle_cnt == IDLE_W'(BLANK_CYCLES - 1));
        take_fresh   = (state == IDLE) && spd_vld;
        take_slot    = (state == IDLE) && !spd_vld && slot_vld;
        take_sample  = take_fresh || take_slot;
        take_blank   = (state == IDLE) && !take_sample && (blank_pend || timeout_fire);
        raw          = take_fresh ? spd : slot_dat;
        peak_grow    = raw > peak;
        src          = peak_mode ? max8(peak, raw) : raw;
        sample_go    = take_sample && (!peak_mode || peak_grow);
        sat          = src > BCD_LIMIT;
        go_conv      = sample_go && !sat;
        go_direct    = (sample_go && sat) || take_blank;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (go_conv) begin
                    next_state = CONV;
                end else if (go_direct) begin
                    next_state = NOTIFY;
                end
            end
            CONV: begin
                if (conv_done) begin
                    next_state = NOTIFY;
                end
            end
            NOTIFY: begin
                if (noti && (noti_cnt == NOTI_W'(NOTI_CYCLES))) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Direct entries into NOTIFY arrive with noti low and raise it one clock later.
    always_comb begin
        busy     = (state != IDLE);
        msg_load = ((state == CONV) && conv_done) || ((state == NOTIFY) && !noti);
        msg_next = (state == CONV) ? {conv_tens, conv_ones} : code_q;
        ovf_next = (state == CONV) ? 1'b0 : code_ovf_q;
        noti_end = (state == NOTIFY) && noti && (noti_cnt == NOTI_W'(NOTI_CYCLES));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg         <= 8'h00;
            noti        <= 1'b0;
            ovf         <= 1'b0;
            noti_cnt    <= '0;
            peak        <= 8'h00;
            peak_mode_q <= 1'b0;
            slot_vld    <= 1'b0;
            slot_dat    <= 8'h00;
            idle_cnt    <= '0;
            armed       <= 1'b1;
            blank_pend  <= 1'b0;
            code_q      <= 8'h00;
            code_ovf_q  <= 1'b0;
        end else begin
            peak_mode_q <= peak_mode;
            if (peak_mode_q && !peak_mode) begin
                peak <= 8'h00;
            end else if (take_sample && peak_mode && peak_grow) begin
                peak <= raw;
            end

            if (spd_vld && (state != IDLE)) begin
                slot_vld <= 1'b1;
                slot_dat <= spd;
            end else if (take_sample) begin
                slot_vld <= 1'b0;
            end

            // One blank per idle period: disarm on firing, re-arm on the next strobe.
            if (spd_vld) begin
                idle_cnt <= '0;
                armed    <= 1'b1;
            end else if (timeout_fire) begin
                idle_cnt <= '0;
                armed    <= 1'b0;
            end else if (armed) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end

            if (spd_vld) begin
                blank_pend <= 1'b0;
            end else if (timeout_fire && !take_blank) begin
                blank_pend <= 1'b1;
            end else if (take_blank) begin
                blank_pend <= 1'b0;
            end

            if (go_direct) begin
                code_q     <= take_blank ? BLANK_CODE : OVF_CODE;
                code_ovf_q <= !take_blank;
            end

            if (msg_load) begin
                msg      <= msg_next;
                ovf      <= ovf_next;
                noti     <= 1'b1;
                noti_cnt <= NOTI_W'(1);
            end else if (noti_end) begin
                noti     <= 1'b0;
                noti_cnt <= '0;
            end else if (noti) begin
                noti_cnt <= noti_cnt + NOTI_W'(1);
            end
        end
    end

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (go_conv),
        .value (src[6:0]),
        .done  (conv_done),
        .tens  (conv_tens),
        .ones  (conv_ones)
    );

endmodule

// File: tb/tb_speed_display_ctrl.sv
// Directed stimulus with a scoreboard queue; a negedge monitor checks every noti pulse.
module tb_speed_display_ctrl;

    localparam int NOTI  = 4;
    localparam int BLANK = 20;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic [7:0] spd       = 8'h00;
    logic       spd_vld   = 1'b0;
    logic       peak_mode = 1'b0;
    logic [7:0] msg;
    logic       noti;
    logic       busy;
    logic       ovf;

    always #5 clk = ~clk;

    speed_display_ctrl #(
        .NOTI_CYCLES  (NOTI),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spd       (spd),
        .spd_vld   (spd_vld),
        .peak_mode (peak_mode),
        .msg       (msg),
        .noti      (noti),
        .busy      (busy),
        .ovf       (ovf)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] msg;
        logic       ovf;
        int         rise;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic push(input logic [7:0] m, input logic o, input int rise);
        exp_t x;
        x.msg  = m;
        x.ovf  = o;
        x.rise = rise;
        sbq.push_back(x);
    endtask

    // Returns the number of the clock edge that samples the strobe.
    task automatic send(input logic [7:0] v, output int n);
        @(negedge clk);
        spd     = v;
        spd_vld = 1'b1;
        n       = cyc + 1;
        @(negedge clk);
        spd_vld = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy && !noti) return;
        end
        checks++;
        failures++;
        $display("FAIL %s: controller still busy after 200 clocks", tag);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sbq.size() == 0) return;
            @(negedge clk);
        end
        checks++;
        failures++;
        $display("FAIL %s: %0d expected updates never arrived", tag, sbq.size());
    endtask

    logic       noti_q = 1'b0;
    int         width  = 0;
    logic [7:0] held   = 8'h00;

    always @(negedge clk) begin
        if (rst_n) begin
            if (noti && !noti_q) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_noti: msg=0x%0h at edge %0d, no update expected", msg, cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("upd_msg", msg, e.msg);
                    chk("upd_ovf", ovf, e.ovf);
                    chk("busy_at_rise", busy, 1);
                    if (e.rise >= 0) chk("rise_edge", cyc, e.rise);
                end
                held  = msg;
                width = 1;
            end else if (noti) begin
                width++;
            end else if (noti_q) begin
                chk("noti_width", width, NOTI);
                chk("msg_hold", msg, held);
                chk("busy_at_fall", busy, 0);
            end
        end
        noti_q = noti;
    end

    int n;

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_msg", msg, 8'h00);
        chk("rst_noti", noti, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Plain conversions, saturation, and the idle blank.
        send(8'd47, n);  push(8'h47, 1'b0, n + 6);
        wait_idle("conv47");
        send(8'd200, n); push(8'h99, 1'b1, n + 1);
        wait_idle("sat200");
        send(8'd3, n);   push(8'h03, 1'b0, n + 2);
        push(8'hFF, 1'b0, n + 21);
        wait_drain("blank1", 100);
        repeat (60) @(negedge clk);
        send(8'd7, n);   push(8'h07, 1'b0, n + 2);
        wait_idle("conv7");

        // Peak hold.
        peak_mode = 1'b1;
        send(8'd30, n);  push(8'h30, 1'b0, n + 5);
        wait_idle("peak30");
        send(8'd55, n);  push(8'h55, 1'b0, n + 7);
        wait_idle("peak55");
        send(8'd40, n);
        repeat (3) @(negedge clk);
        chk("peak_discard_busy", busy, 0);
        peak_mode = 1'b0;
        @(negedge clk);
        send(8'd12, n);  push(8'h12, 1'b0, n + 3);
        wait_idle("live12");

        // Back-to-back strobes: the parked sample is overwritten.
        @(negedge clk);
        spd = 8'd88; spd_vld = 1'b1; n = cyc + 1;
        @(negedge clk);
        spd = 8'd21;
        @(negedge clk);
        spd = 8'd64;
        @(negedge clk);
        spd_vld = 1'b0;
        push(8'h88, 1'b0, n + 10);
        push(8'h64, 1'b0, n + 23);
        push(8'hFF, 1'b0, n + 29);
        wait_drain("slot", 200);
        wait_idle("slot_blank");

        // Reset in the middle of a conversion.
        send(8'd250, n); push(8'h99, 1'b1, n + 1);
        wait_idle("sat250");
        send(8'd99, n);
        repeat (3) @(negedge clk);
        chk("pre_rst_msg", msg, 8'h99);
        chk("pre_rst_ovf", ovf, 1);
        chk("pre_rst_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_msg", msg, 8'h00);
        chk("midrst_noti", noti, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'd10, n);  push(8'h10, 1'b0, n + 3);
        push(8'hFF, 1'b0, n + 21);
        wait_drain("post_rst", 100);
        repeat (60) @(negedge clk);

        chk("sb_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
